// File: rtl/vga_pkg.sv
// Shared VGA timing definitions for the 640x480@60 mode.
// Imported by the scan counter and by the horizontal/vertical comparators.
package vga_pkg;

    // Horizontal timing, in pixels
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;   // 800

    // Vertical timing, in lines
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;   // 525

    // Scan position as seen by the comparators
    typedef logic [9:0] scan_t;

    // True when a counter of 'bits' width can hold every value 0..total-1
    function automatic bit scan_fits(input int bits, input int total);
        return (64'(1) << bits) >= 64'(total);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with asynchronous clear.
// 'wrap' flags the increment that returns the count to zero, so cascading
// wrap into the next stage's inc builds a chain of dividers.
module mod_counter #(
    parameter int W   = 4,
    parameter int MOD = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // Reject configurations where the count could not be represented
    if (MOD < 2) begin : g_bad_mod
        $error("mod_counter: MOD must be at least 2");
    end
    if (!vga_pkg::scan_fits(W, MOD)) begin : g_bad_width
        $error("mod_counter: W too narrow for MOD");
    end

    // Terminal-count decode; only meaningful on an incrementing cycle
    assign wrap = inc && (q == LAST);

    // Count on inc, returning straight to zero from MOD-1 (never reaches MOD)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc) begin
            if (wrap) begin
                q <= '0;
            end else begin
                q <= q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_scan_counter.sv
// Pixel-timing source: system clock divider followed by horizontal and
// vertical scan counters, plus line/frame strobes and the visible flag.
// The three stages are a cascade of mod_counter instances; each stage's
// wrap is the next stage's increment, so a line wrap and a frame wrap on
// the same edge happen together as a single event.
module vga_scan_counter #(
    parameter int N         = 9,
    parameter int DIV       = 2,
    parameter int H_TOTAL   = vga_pkg::H_TOTAL,
    parameter int V_TOTAL   = vga_pkg::V_TOTAL,
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [N:0] countH,
    output logic [N:0] countV,
    output logic       pix_tick,
    output logic       line_end,
    output logic       frame_end,
    output logic       video_on
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [N:0] H_VIS_LIMIT = (N + 1)'(H_VISIBLE);
    localparam logic [N:0] V_VIS_LIMIT = (N + 1)'(V_VISIBLE);

    // Configuration sanity
    if (DIV < 2) begin : g_bad_div
        $error("vga_scan_counter: DIV must be at least 2");
    end
    if (!vga_pkg::scan_fits(N + 1, H_TOTAL) || !vga_pkg::scan_fits(N + 1, V_TOTAL)) begin : g_bad_n
        $error("vga_scan_counter: N too small for H_TOTAL/V_TOTAL");
    end

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    logic             h_wrap;
    logic             v_wrap;

    // Divider: advances on every enabled clock; its wrap is the pixel tick
    mod_counter #(
        .W   (DIV_W),
        .MOD (DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .inc  (en),
        .q    (div_cnt),
        .wrap (div_wrap)
    );

    // Horizontal position: one step per pixel tick
    mod_counter #(
        .W   (N + 1),
        .MOD (H_TOTAL)
    ) u_h (
        .clk  (clk),
        .rst  (rst),
        .inc  (div_wrap),
        .q    (countH),
        .wrap (h_wrap)
    );

    // Vertical position: one step per completed line
    mod_counter #(
        .W   (N + 1),
        .MOD (V_TOTAL)
    ) u_v (
        .clk  (clk),
        .rst  (rst),
        .inc  (h_wrap),
        .q    (countV),
        .wrap (v_wrap)
    );

    // Strobes come straight from the wrap decodes, so each is one clock wide
    // and lines up with the tick that moves the counters. The divider wrap
    // already includes en, so every strobe is low while frozen.
    assign pix_tick  = div_wrap;
    assign line_end  = h_wrap;
    assign frame_end = v_wrap;

    // Visible area follows the held position even while en is low
    assign video_on = (countH < H_VIS_LIMIT) && (countV < V_VIS_LIMIT);

endmodule
